// File: rtl/controle_de_acesso_pkg.sv
// controle_de_acesso_pkg: controller states, user codes and default permission matrix
package controle_de_acesso_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, DENY, LOCKED} state_t;
   localparam logic [2:0] ADMIN = 3'b101;
   localparam logic [2:0] OPER  = 3'b011;
   // one 7-bit row per user, bit f-1 = function f; OPER lacks functions 5 and 7
   localparam logic [55:0] PERM_DEFAULT = (56'h7F << (ADMIN * 7)) | (56'h2F << (OPER * 7));
endpackage

// File: rtl/tabela_de_permissao.sv
// tabela_de_permissao: combinational lookup of (user, func) into grant / invalid
module tabela_de_permissao
   import controle_de_acesso_pkg::*;
#(
   parameter int USER_W = 3,
   parameter int FUNC_W = 3,
   parameter int N_FUNC = 7,
   parameter logic [(2**USER_W)*N_FUNC-1:0] PERM = PERM_DEFAULT
) (
   input  logic [USER_W-1:0] user,
   input  logic [FUNC_W-1:0] func,
   output logic              grant,
   output logic              invalid
);
   always_comb begin
      grant = 1'b0;
      for (int u = 0; u < 2**USER_W; u++)
         for (int f = 1; f <= N_FUNC; f++)
            if (user == USER_W'(u) && func == FUNC_W'(f)) grant = PERM[u*N_FUNC+f-1];
   end
   assign invalid = func == '0 || func > FUNC_W'(N_FUNC);
endmodule

// File: rtl/controle_de_acesso.sv
// controle_de_acesso: access-control FSM; define CONTROLE_DE_ACESSO_LOCKOUT_EN for fail lockout
module controle_de_acesso
   import controle_de_acesso_pkg::*;
#(
   parameter int USER_W      = 3,
   parameter int FUNC_W      = 3,
   parameter int N_FUNC      = 7,
   parameter int HOLD_CYCLES = 4,
   parameter logic [(2**USER_W)*N_FUNC-1:0] PERM = PERM_DEFAULT,
   parameter int MAX_FAILS   = 3,
   parameter int LOCK_CYCLES = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [USER_W-1:0] user,
   input  logic [FUNC_W-1:0] func,
   output logic              ready,
   output logic              granted,
   output logic              err,
   output logic [N_FUNC-1:0] matrix_n,
   output logic [N_FUNC-1:0] led,
   output logic              locked
);
   localparam int CNT_MAX = HOLD_CYCLES > LOCK_CYCLES ? HOLD_CYCLES : LOCK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
   if (N_FUNC > 2**FUNC_W - 1 || HOLD_CYCLES < 1 || LOCK_CYCLES < 1 || MAX_FAILS < 1) begin : g_bad_cfg
      $error("controle_de_acesso: invalid parameter set");
   end
   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [FUNC_W-1:0] func_q, func_d;
   logic              err_q, err_d;
   logic              grant_w, invalid_w;
   logic [N_FUNC-1:0] sel;
`ifdef CONTROLE_DE_ACESSO_LOCKOUT_EN
   logic [FAIL_W-1:0] fails, fails_d;
`endif
   tabela_de_permissao #(
      .USER_W(USER_W), .FUNC_W(FUNC_W), .N_FUNC(N_FUNC), .PERM(PERM)
   ) u_tabela (
      .user(user), .func(func), .grant(grant_w), .invalid(invalid_w)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         func_q <= '0;
         err_q  <= 1'b0;
`ifdef CONTROLE_DE_ACESSO_LOCKOUT_EN
         fails  <= '0;
`endif
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         func_q <= func_d;
         err_q  <= err_d;
`ifdef CONTROLE_DE_ACESSO_LOCKOUT_EN
         fails  <= fails_d;
`endif
      end
   end
   always_comb begin
      state_d = state;
      cnt_d   = cnt + CNT_W'(1);
      func_d  = func_q;
      err_d   = err_q;
`ifdef CONTROLE_DE_ACESSO_LOCKOUT_EN
      fails_d = fails;
`endif
      case (state)
         IDLE: begin
            cnt_d = '0;
            if (req) begin
               state_d = grant_w ? GRANT : DENY;
               func_d  = func;
               err_d   = invalid_w;
`ifdef CONTROLE_DE_ACESSO_LOCKOUT_EN
               fails_d = grant_w ? '0 : fails + FAIL_W'(1);
`endif
            end
         end
         GRANT, DENY: if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_d = '0;
`ifdef CONTROLE_DE_ACESSO_LOCKOUT_EN
            state_d = state == DENY && fails >= FAIL_W'(MAX_FAILS) ? LOCKED : IDLE;
`else
            state_d = IDLE;
`endif
         end
`ifdef CONTROLE_DE_ACESSO_LOCKOUT_EN
         LOCKED: if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            cnt_d   = '0;
            fails_d = '0;
            state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   // held outputs come only from latched func/err, never from the live inputs
   assign sel      = N_FUNC'(1) << (func_q - FUNC_W'(1));
   assign ready    = state == IDLE;
   assign granted  = state == GRANT;
   assign err      = state == DENY && err_q;
   assign matrix_n = granted ? ~sel : '1;
   assign led      = state == DENY && !err_q ? sel : '0;
`ifdef CONTROLE_DE_ACESSO_LOCKOUT_EN
   assign locked   = state == LOCKED;
`else
   assign locked   = 1'b0;
`endif
endmodule

// File: tb/tb_controle_de_acesso.sv
// tb_controle_de_acesso: scoreboard bench for the access controller
module tb_controle_de_acesso;
   localparam int HOLD = 4;
   localparam int LOCK = 8;
   localparam logic [17:0] IDLE_V = {4'b1000, 7'h7F, 7'h00};
   localparam logic [17:0] LOCK_V = {4'b0001, 7'h7F, 7'h00};
   logic       clk = 1'b0;
   logic       reset, req;
   logic [2:0] user, func;
   logic       ready, granted, err, locked;
   logic [6:0] matrix_n, led;
   logic [17:0] sb[$];
   int checks = 0;
   int errors = 0;
   int fails_m = 0;
   controle_de_acesso dut (
      .clk(clk), .reset(reset), .req(req), .user(user), .func(func),
      .ready(ready), .granted(granted), .err(err),
      .matrix_n(matrix_n), .led(led), .locked(locked)
   );
   always #5 clk = ~clk;
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end
   // {ready, granted, err, locked, matrix_n, led}
   function automatic logic [17:0] obs();
      return {ready, granted, err, locked, matrix_n, led};
   endfunction
   function automatic logic [17:0] exp_hold(input logic [2:0] u, input logic [2:0] f);
      logic [6:0] oh;
      logic ok;
      if (f == 3'd0) return {4'b0010, 7'h7F, 7'h00};
      oh = 7'd1 << (f - 3'd1);
      ok = (u == 3'b101) || (u == 3'b011 && f != 3'd5 && f != 3'd7);
      return ok ? {4'b0100, ~oh, 7'h00} : {4'b0000, 7'h7F, oh};
   endfunction
   function automatic void expect_txn(input logic [2:0] u, input logic [2:0] f);
      logic [17:0] h;
      h = exp_hold(u, f);
      for (int i = 0; i < HOLD; i++) sb.push_back(h);
`ifdef CONTROLE_DE_ACESSO_LOCKOUT_EN
      if (h[16]) fails_m = 0;
      else begin
         fails_m = fails_m + 1;
         if (fails_m == 3) begin
            for (int i = 0; i < LOCK; i++) sb.push_back(LOCK_V);
            fails_m = 0;
         end
      end
`endif
      sb.push_back(IDLE_V);
   endfunction
   task automatic go(input logic [2:0] u, input logic [2:0] f);
      @(negedge clk);
      req = 1'b1; user = u; func = f;
      expect_txn(u, f);
   endtask
   task automatic test_reset();
      logic [17:0] e, got;
      reset = 1'b1; req = 1'b1; user = 3'b101; func = 3'd1;
      fails_m = 0;
      repeat (3) sb.push_back(IDLE_V);
      for (int n = 0; sb.size() != 0; n++) begin
         @(negedge clk);
         e = sb.pop_front(); got = obs();
         reset = n < 1; req = n < 1;
         checks++;
         if (got !== e) begin errors++; $display("FAIL reset[%0d]: got %h want %h", n, got, e); end
      end
   endtask
   task automatic test_grant();
      logic [17:0] e, got;
      go(3'b101, 3'd7);
      while (sb.size() != 0) begin
         @(negedge clk);
         e = sb.pop_front(); got = obs();
         req = 1'b0; user = 3'($urandom); func = 3'($urandom);
         checks++;
         if (got !== e) begin errors++; $display("FAIL grant: got %h want %h", got, e); end
      end
   endtask
   task automatic test_deny();
      logic [17:0] e, got;
      logic [5:0] tbl [6] = '{{3'b011, 3'd5}, {3'b001, 3'd0}, {3'b001, 3'd7},
                              {3'b011, 3'd6}, {3'b110, 3'd3}, {3'b000, 3'd0}};
      foreach (tbl[k]) begin
         go(tbl[k][5:3], tbl[k][2:0]);
         while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); got = obs();
            req = 1'b0; user = 3'($urandom); func = 3'($urandom);
            checks++;
            if (got !== e) begin errors++; $display("FAIL deny[%0d] u=%0d f=%0d: got %h want %h", k, tbl[k][5:3], tbl[k][2:0], got, e); end
         end
      end
   endtask
   task automatic test_ignore();
      logic [17:0] e, got;
      go(3'b101, 3'd1);
      while (sb.size() != 0) begin
         @(negedge clk);
         e = sb.pop_front(); got = obs();
         req = sb.size() > 1; user = 3'b101; func = 3'd2;
         checks++;
         if (got !== e) begin errors++; $display("FAIL ignore: got %h want %h", got, e); end
      end
   endtask
   task automatic test_back_to_back();
      logic [17:0] e, got;
      go(3'b011, 3'd1);
      expect_txn(3'b011, 3'd6);
      while (sb.size() != 0) begin
         @(negedge clk);
         e = sb.pop_front(); got = obs();
         req = sb.size() == HOLD + 1; user = 3'b011; func = 3'd6;
         checks++;
         if (got !== e) begin errors++; $display("FAIL back_to_back: got %h want %h", got, e); end
      end
   endtask
   task automatic test_reset_mid();
      logic [17:0] e, got;
      @(negedge clk);
      req = 1'b1; user = 3'b101; func = 3'd1;
      repeat (2) sb.push_back(exp_hold(3'b101, 3'd1));
      repeat (2) sb.push_back(IDLE_V);
      fails_m = 0;
      for (int n = 0; sb.size() != 0; n++) begin
         @(negedge clk);
         e = sb.pop_front(); got = obs();
         reset = n == 1; req = n == 1; func = 3'd3;
         checks++;
         if (got !== e) begin errors++; $display("FAIL reset_mid[%0d]: got %h want %h", n, got, e); end
      end
   endtask
`ifdef CONTROLE_DE_ACESSO_LOCKOUT_EN
   task automatic test_lockout();
      logic [17:0] e, got;
      logic [5:0] tbl [6] = '{{3'b110, 3'd1}, {3'b110, 3'd2}, {3'b101, 3'd3},
                              {3'b110, 3'd1}, {3'b001, 3'd0}, {3'b110, 3'd7}};
      foreach (tbl[k]) begin
         go(tbl[k][5:3], tbl[k][2:0]);
         while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front(); got = obs();
            req = e[14]; user = 3'b101; func = 3'd1;
            checks++;
            if (got !== e) begin errors++; $display("FAIL lockout[%0d]: got %h want %h", k, got, e); end
         end
      end
   endtask
`endif
   initial begin
      test_reset();
      test_grant();
      test_deny();
      test_ignore();
      test_back_to_back();
      test_reset_mid();
`ifdef CONTROLE_DE_ACESSO_LOCKOUT_EN
      test_lockout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
